// File: rtl/fabscalar_pkg.sv
// rtl/fabscalar_pkg.sv - shared sizes and tag/index types for the rename free list
package fabscalar_pkg;
  localparam int SIZE_PHYSICAL_TABLE = 96;
  localparam int SIZE_RMT            = 32;
  localparam int FREE_LIST_DEPTH     = SIZE_PHYSICAL_TABLE - SIZE_RMT;
  localparam int FL_INDEX            = $clog2(FREE_LIST_DEPTH);
  localparam int PHY_REG_BITS        = 7;
  localparam int DISPATCH_WIDTH      = 4;
  localparam int COMMIT_WIDTH        = 4;

  typedef logic [PHY_REG_BITS-1:0] phys_reg_t;
  typedef logic [FL_INDEX-1:0]     fl_idx_t;
  typedef logic [FL_INDEX:0]       fl_cnt_t;

  localparam fl_cnt_t FL_DEPTH_CNT = fl_cnt_t'(FREE_LIST_DEPTH);
  localparam fl_cnt_t DISPATCH_CNT = fl_cnt_t'(DISPATCH_WIDTH);
endpackage

// File: rtl/free_list_ctrl_if.sv
// rtl/free_list_ctrl_if.sv - rename/commit side bundle of the free list (FREE_LIST_STATS_EN adds stats)
interface free_list_ctrl_if;
  import fabscalar_pkg::*;

  logic [DISPATCH_WIDTH-1:0] reqFreeReg_i;
  phys_reg_t                 freeReg0_o;
  phys_reg_t                 freeReg1_o;
  phys_reg_t                 freeReg2_o;
  phys_reg_t                 freeReg3_o;
  logic [DISPATCH_WIDTH-1:0] freeRegValid_o;
  logic                      freeListEmpty_o;
  phys_reg_t                 freedReg0_i;
  phys_reg_t                 freedReg1_i;
  phys_reg_t                 freedReg2_i;
  phys_reg_t                 freedReg3_i;
  logic [COMMIT_WIDTH-1:0]   freedValid_i;
`ifdef FREE_LIST_STATS_EN
  fl_cnt_t                   freeCnt_o;
  fl_cnt_t                   minFreeCnt_o;

  modport master (
    output reqFreeReg_i, freedReg0_i, freedReg1_i, freedReg2_i, freedReg3_i, freedValid_i,
    input  freeReg0_o, freeReg1_o, freeReg2_o, freeReg3_o, freeRegValid_o, freeListEmpty_o,
    input  freeCnt_o, minFreeCnt_o
  );
  modport slave (
    input  reqFreeReg_i, freedReg0_i, freedReg1_i, freedReg2_i, freedReg3_i, freedValid_i,
    output freeReg0_o, freeReg1_o, freeReg2_o, freeReg3_o, freeRegValid_o, freeListEmpty_o,
    output freeCnt_o, minFreeCnt_o
  );
`else
  modport master (
    output reqFreeReg_i, freedReg0_i, freedReg1_i, freedReg2_i, freedReg3_i, freedValid_i,
    input  freeReg0_o, freeReg1_o, freeReg2_o, freeReg3_o, freeRegValid_o, freeListEmpty_o
  );
  modport slave (
    input  reqFreeReg_i, freedReg0_i, freedReg1_i, freedReg2_i, freedReg3_i, freedValid_i,
    output freeReg0_o, freeReg1_o, freeReg2_o, freeReg3_o, freeRegValid_o, freeListEmpty_o
  );
`endif
endinterface

// File: rtl/free_list_compact.sv
// rtl/free_list_compact.sv - 4-lane mask to per-lane prefix offsets and total popcount
module free_list_compact (
  input  logic [3:0]      mask,
  output logic [3:0][1:0] offset,
  output logic [2:0]      count
);
  logic [2:0] acc;

  // Running prefix sum: each lane's offset is the number of set lanes below it.
  always_comb begin
    acc    = '0;
    offset = '0;
    for (int k = 0; k < 4; k++) begin
      offset[k] = acc[1:0];
      acc       = acc + {2'b00, mask[k]};
    end
    count = acc;
  end
endmodule

// File: rtl/free_list_ctrl.sv
// rtl/free_list_ctrl.sv - circular physical-tag free list with rename stall (FREE_LIST_STATS_EN adds count/low-water ports)
module free_list_ctrl
  import fabscalar_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  free_list_ctrl_if.slave fl
);
  phys_reg_t                  entry     [FREE_LIST_DEPTH];
  phys_reg_t                  wr_data   [FREE_LIST_DEPTH];
  logic [FREE_LIST_DEPTH-1:0] wr_en;
  phys_reg_t                  freed_tag [COMMIT_WIDTH];
  phys_reg_t                  rd_tag    [DISPATCH_WIDTH];
  fl_idx_t                    head;
  fl_idx_t                    tail;
  fl_cnt_t                    cnt;
  fl_cnt_t                    cnt_next;
  logic [3:0][1:0]            pop_off;
  logic [3:0][1:0]            push_off;
  logic [2:0]                 pop_num;
  logic [2:0]                 push_num;
  logic [2:0]                 pop_eff;
  logic                       empty;

  assign freed_tag[0] = fl.freedReg0_i;
  assign freed_tag[1] = fl.freedReg1_i;
  assign freed_tag[2] = fl.freedReg2_i;
  assign freed_tag[3] = fl.freedReg3_i;

  free_list_compact u_pop  (.mask(fl.reqFreeReg_i), .offset(pop_off),  .count(pop_num));
  free_list_compact u_push (.mask(fl.freedValid_i), .offset(push_off), .count(push_num));

  // Stall whenever a full dispatch group cannot be served; reset forces the stall.
  assign empty    = reset | (cnt < DISPATCH_CNT);
  assign pop_eff  = empty ? 3'd0 : pop_num;
  assign cnt_next = cnt - fl_cnt_t'(pop_eff) + fl_cnt_t'(push_num);

  // Requesting slots are packed onto consecutive entries starting at head.
  always_comb begin
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      rd_tag[k] = entry[head + fl_idx_t'(pop_off[k])];
    end
  end

  assign fl.freeReg0_o      = rd_tag[0];
  assign fl.freeReg1_o      = rd_tag[1];
  assign fl.freeReg2_o      = rd_tag[2];
  assign fl.freeReg3_o      = rd_tag[3];
  assign fl.freeRegValid_o  = fl.reqFreeReg_i & {DISPATCH_WIDTH{~empty}};
  assign fl.freeListEmpty_o = empty;

  // Valid release lanes are packed onto consecutive entries starting at tail.
  always_comb begin
    wr_en = '0;
    for (int e = 0; e < FREE_LIST_DEPTH; e++) begin
      wr_data[e] = '0;
    end
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (fl.freedValid_i[k]) begin
        wr_en[tail + fl_idx_t'(push_off[k])]   = 1'b1;
        wr_data[tail + fl_idx_t'(push_off[k])] = freed_tag[k];
      end
    end
  end

  // One register per entry: reset loads the tags not held by the architectural map.
  for (genvar e = 0; e < FREE_LIST_DEPTH; e++) begin : g_entry
    always_ff @(posedge clk) begin
      if (reset) begin
        entry[e] <= phys_reg_t'(e + SIZE_RMT);
      end else if (wr_en[e]) begin
        entry[e] <= wr_data[e];
      end
    end
  end

  // Head/tail wrap naturally at the index width; the count disambiguates full from empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= FL_DEPTH_CNT;
    end else begin
      head <= head + fl_idx_t'(pop_eff);
      tail <= tail + fl_idx_t'(push_num);
      cnt  <= cnt_next;
    end
  end

`ifdef FREE_LIST_STATS_EN
  fl_cnt_t min_cnt;

  // Low-water mark of the free count since the last reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      min_cnt <= FL_DEPTH_CNT;
    end else if (cnt_next < min_cnt) begin
      min_cnt <= cnt_next;
    end
  end

  assign fl.freeCnt_o    = cnt;
  assign fl.minFreeCnt_o = min_cnt;
`endif
endmodule
